router_out_reader: RTL and testbench

- Destination-side consumer for one router output port. It drains that port's output FIFO by driving read_enb from the synchronizer's vld_out and soft_reset, and parses each packet as header, payload and parity.
- Every byte goes to a downstream valid/ready stream through a small credit-controlled buffer.
- At packet end it checks parity and reports done, error or abort.
- One instance per output port (3 per router).

---
 rtl/router_out_reader.sv | 179 +++++++++++++++++
 tb/tb_router_out_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_reader.sv
// Destination-side reader for one router output port.
// Drains the port FIFO under a credit limit, parses header/payload/parity,
// and forwards every byte through a small valid/ready buffer.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   IDLE         | waiting for a header; a read here starts a packet
//   HDR_WAIT     | header read in flight; latch length and seed parity
//   PAYLOAD      | issuing payload reads, counting remaining down to 1
//   PARITY_RD    | issue the single parity-byte read
//   PARITY_WAIT  | parity byte in flight; compare, tag last, report done
module router_out_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 6,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  vld_out,
   input  logic                  soft_reset,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  read_enb,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  pkt_done,
   output logic                  pkt_err,
   output logic                  pkt_abort,
   output logic                  busy
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(BUF_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_HDR_WAIT    = 3'd1;
   localparam logic [2:0] S_PAYLOAD     = 3'd2;
   localparam logic [2:0] S_PARITY_RD   = 3'd3;
   localparam logic [2:0] S_PARITY_WAIT = 3'd4;

   logic [2:0]            state;
   logic [2:0]            state_nxt;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [LEN_WIDTH-1:0]  remaining_nxt;
   logic [DATA_WIDTH-1:0] parity_acc;
   logic [DATA_WIDTH-1:0] parity_nxt;
   logic [LEN_WIDTH-1:0]  hdr_len;
   logic                  rd_pending;

   logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
   logic                  buf_last [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      buf_count;
   logic [OCC_W-1:0]      occupancy;

   logic                  state_reads;
   logic                  push;
   logic                  pop;
   logic                  parity_cap;

   // Credit: bytes already buffered plus the one possibly in flight from the FIFO.
   // resetn gates the strobe so the FIFO is never popped while the block is held in reset.
   always_comb begin
      occupancy   = OCC_W'(buf_count) + OCC_W'(rd_pending);
      state_reads = (state == S_IDLE) || (state == S_PAYLOAD) || (state == S_PARITY_RD);
      read_enb    = resetn & vld_out & state_reads & (occupancy < DEPTH_C) & ~soft_reset;
   end

   // Capture-side strobes and status outputs.
   always_comb begin
      hdr_len    = fifo_dout[LEN_WIDTH+1:2];
      push       = rd_pending & ~soft_reset;
      out_valid  = (buf_count != '0);
      pop        = out_valid & out_ready & ~soft_reset;
      out_data   = buf_data[rd_ptr];
      out_last   = buf_last[rd_ptr];
      parity_cap = (state == S_PARITY_WAIT) & rd_pending;
      pkt_done   = parity_cap & ~soft_reset;
      pkt_err    = pkt_done & (parity_acc != fifo_dout);
      busy       = (state != S_IDLE);
   end

   // Next-state, length countdown and parity accumulation.
   // Payload bytes fold into parity when they arrive, not when they are requested.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      parity_nxt    = parity_acc;
      case (state)
         S_IDLE: begin
            if (read_enb) state_nxt = S_HDR_WAIT;
         end
         S_HDR_WAIT: begin
            if (rd_pending) begin
               remaining_nxt = hdr_len;
               parity_nxt    = fifo_dout;
               state_nxt     = (hdr_len != '0) ? S_PAYLOAD : S_PARITY_RD;
            end
         end
         S_PAYLOAD: begin
            if (rd_pending) parity_nxt = parity_acc ^ fifo_dout;
            if (read_enb) begin
               remaining_nxt = remaining - 1'b1;
               if (remaining == LEN_WIDTH'(1)) state_nxt = S_PARITY_RD;
            end
         end
         S_PARITY_RD: begin
            if (rd_pending) parity_nxt = parity_acc ^ fifo_dout;
            if (read_enb) state_nxt = S_PARITY_WAIT;
         end
         S_PARITY_WAIT: begin
            if (rd_pending) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (soft_reset) begin
         state_nxt     = S_IDLE;
         remaining_nxt = '0;
         parity_nxt    = '0;
      end
   end

   // FSM, counters, read-in-flight flag and abort pulse.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         remaining  <= '0;
         parity_acc <= '0;
         rd_pending <= 1'b0;
         pkt_abort  <= 1'b0;
      end else begin
         state      <= state_nxt;
         remaining  <= remaining_nxt;
         parity_acc <= parity_nxt;
         rd_pending <= read_enb;
         pkt_abort  <= soft_reset & (busy | out_valid);
      end
   end

   // Output buffer storage; the last flag rides with the parity byte.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_data[i] <= '0;
            buf_last[i] <= 1'b0;
         end
      end else if (push) begin
         buf_data[wr_ptr] <= fifo_dout;
         buf_last[wr_ptr] <= parity_cap;
      end
   end

   // Buffer pointers and fill count; soft_reset empties the buffer.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         buf_count <= '0;
      end else if (soft_reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         buf_count <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   buf_count <= buf_count + 1'b1;
            2'b01:   buf_count <= buf_count - 1'b1;
            default: buf_count <= buf_count;
         endcase
      end
   end

endmodule

// File: tb/tb_router_out_reader.sv
// Directed bench for router_out_reader with a behavioural FIFO feeding it
// and a stream monitor collecting the forwarded bytes.
module tb_router_out_reader;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       vld_out = 1'b0;
   logic       soft_reset = 1'b0;
   logic [7:0] fifo_dout = 8'h00;
   logic       read_enb;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_last;
   logic       pkt_done;
   logic       pkt_err;
   logic       pkt_abort;
   logic       busy;

   router_out_reader #(.DATA_WIDTH(8), .LEN_WIDTH(6), .BUF_DEPTH(4)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .vld_out    (vld_out),
      .soft_reset (soft_reset),
      .fifo_dout  (fifo_dout),
      .read_enb   (read_enb),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .pkt_done   (pkt_done),
      .pkt_err    (pkt_err),
      .pkt_abort  (pkt_abort),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   // FIFO contents: written by the stimulus, consumed by the FIFO model.
   logic [7:0] pkt_mem [0:511];
   int         wr_idx = 0;
   int         rd_idx = 0;
   logic       vld_gate = 1'b1;
   logic       rd_take = 1'b0;

   logic [8:0] rx_q [$];
   logic [8:0] exp_q [$];
   int rd_cnt = 0, viol_cnt = 0, done_cnt = 0, err_cnt = 0, abort_cnt = 0;
   int n_checks = 0, n_fail = 0;
   int base, rd0, d0, e0, a0, v0;
   logic [7:0] par;

   // Mid-cycle monitor: reads issued, handshakes, status pulses.
   always @(negedge clock) begin
      rd_take = read_enb;
      if (read_enb) begin
         rd_cnt++;
         if (!vld_out) viol_cnt++;
      end
      if (out_valid && out_ready) rx_q.push_back({out_last, out_data});
      if (pkt_done) begin
         done_cnt++;
         if (pkt_err) err_cnt++;
      end
      if (pkt_abort) abort_cnt++;
   end

   // FIFO model: data appears the cycle after read_enb; flushed by either reset.
   always @(posedge clock) begin
      if (!resetn || soft_reset) rd_idx = wr_idx;
      else if (rd_take && rd_idx != wr_idx) begin
         fifo_dout <= pkt_mem[rd_idx];
         rd_idx = rd_idx + 1;
      end
      #2 vld_out = vld_gate && (rd_idx != wr_idx);
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b, input logic last);
      pkt_mem[wr_idx] = b;
      wr_idx = wr_idx + 1;
      exp_q.push_back({last, b});
   endtask

   // Header, payload first+i*step, then parity (or 8'hFF when corrupted).
   task automatic load_pkt(input logic [7:0] hdr, input logic [7:0] first,
                           input logic [7:0] step, input logic corrupt);
      logic [7:0] b;
      int len;
      len = int'(hdr[7:2]);
      par = hdr;
      push_byte(hdr, 1'b0);
      b = first;
      for (int i = 0; i < len; i++) begin
         push_byte(b, 1'b0);
         par = par ^ b;
         b = b + step;
      end
      push_byte(corrupt ? 8'hFF : par, 1'b1);
   endtask

   task automatic wait_rx(input int n, input int limit);
      int c = 0;
      while (rx_q.size() < n && c < limit) begin
         @(posedge clock);
         c++;
      end
      #1;
   endtask

   task automatic check_stream(input string tag, input int from);
      logic [8:0] obs;
      check({tag, "_count"}, rx_q.size() - from, exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
         obs = (from + k < rx_q.size()) ? rx_q[from + k] : 9'h1EE;
         check($sformatf("%s_byte%0d", tag, k), {23'd0, obs}, {23'd0, exp_q[k]});
      end
   endtask

   task automatic mark();
      exp_q.delete();
      base = rx_q.size();
      rd0 = rd_cnt;
      d0 = done_cnt;
      e0 = err_cnt;
   endtask

   initial begin
      // Reset values
      cyc(3);
      check("rst_read_enb", read_enb, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_flags", {out_last, pkt_done, pkt_err, pkt_abort, busy}, 5'b0);
      resetn = 1'b1;
      cyc(2);

      // Good packet, len 3
      out_ready = 1'b1;
      mark();
      load_pkt(8'h0C, 8'h11, 8'h11, 1'b0);
      wait_rx(base + 5, 60);
      cyc(3);
      check_stream("good", base);
      check("good_reads", rd_cnt - rd0, 5);
      check("good_done", done_cnt - d0, 1);
      check("good_err", err_cnt - e0, 0);
      check("good_busy", busy, 1'b0);

      // Corrupted parity byte
      mark();
      load_pkt(8'h0C, 8'h11, 8'h11, 1'b1);
      wait_rx(base + 5, 60);
      cyc(3);
      check_stream("bad", base);
      check("bad_done", done_cnt - d0, 1);
      check("bad_err", err_cnt - e0, 1);

      // Zero-length payload
      mark();
      load_pkt(8'h01, 8'h00, 8'h00, 1'b0);
      wait_rx(base + 2, 60);
      cyc(3);
      check_stream("len0", base);
      check("len0_reads", rd_cnt - rd0, 2);
      check("len0_done", done_cnt - d0, 1);
      check("len0_err", err_cnt - e0, 0);

      // Downstream stall with a 20-byte payload
      out_ready = 1'b0;
      mark();
      load_pkt(8'h50, 8'h01, 8'h01, 1'b0);
      cyc(12);
      check("stall_reads", rd_cnt - rd0, 4);
      check("stall_read_enb", read_enb, 1'b0);
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, 8'h50);
      cyc(5);
      check("stall_data_hold", {out_last, out_data}, 9'h050);
      check("stall_reads_hold", rd_cnt - rd0, 4);
      out_ready = 1'b1;
      wait_rx(base + 22, 300);
      cyc(3);
      check_stream("stall", base);
      check("stall_done", done_cnt - d0, 1);
      check("stall_err", err_cnt - e0, 0);

      // soft_reset while stalled mid-packet
      out_ready = 1'b0;
      mark();
      load_pkt(8'h50, 8'h01, 8'h01, 1'b0);
      cyc(12);
      check("abort_busy_before", busy, 1'b1);
      soft_reset = 1'b1;
      cyc(1);
      soft_reset = 1'b0;
      #1;
      check("abort_valid", out_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_pulse", pkt_abort, 1'b1);
      cyc(1);
      check("abort_pulse_end", pkt_abort, 1'b0);

      // soft_reset while idle and empty, with the FIFO about to offer a header
      mark();
      soft_reset = 1'b1;
      load_pkt(8'h0C, 8'h11, 8'h11, 1'b0);
      #2;
      check("sr_idle_read_enb", read_enb, 1'b0);
      cyc(1);
      soft_reset = 1'b0;
      #1;
      check("sr_idle_no_abort", pkt_abort, 1'b0);
      check("sr_idle_no_reads", rd_cnt - rd0, 0);

      // Clean packet after the abort
      out_ready = 1'b1;
      mark();
      load_pkt(8'h0C, 8'h11, 8'h11, 1'b0);
      wait_rx(base + 5, 60);
      cyc(3);
      check_stream("post_abort", base);
      check("post_abort_done", done_cnt - d0, 1);
      check("post_abort_err", err_cnt - e0, 0);

      // vld_out toggling mid-payload
      mark();
      v0 = viol_cnt;
      load_pkt(8'h30, 8'hA1, 8'h01, 1'b0);
      for (int t = 0; t < 8; t++) begin
         cyc(3);
         vld_gate = ~vld_gate;
      end
      vld_gate = 1'b1;
      wait_rx(base + 14, 200);
      cyc(3);
      check_stream("toggle", base);
      check("toggle_no_read_when_empty", viol_cnt - v0, 0);
      check("toggle_done", done_cnt - d0, 1);
      check("toggle_err", err_cnt - e0, 0);

      // Asynchronous reset mid-payload
      out_ready = 1'b0;
      mark();
      load_pkt(8'h50, 8'h01, 8'h01, 1'b0);
      cyc(8);
      check("arst_busy_before", {busy, out_valid}, 2'b11);
      a0 = abort_cnt;
      @(posedge clock);
      #3;
      resetn = 1'b0;
      #1;
      check("arst_valid", out_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_read_enb", read_enb, 1'b0);
      check("arst_flags", {out_last, pkt_done, pkt_err, pkt_abort}, 4'b0);
      cyc(2);
      resetn = 1'b1;
      cyc(4);
      check("arst_no_abort", abort_cnt - a0, 0);
      check("arst_idle_after", {busy, out_valid}, 2'b00);

      check("global_no_read_when_empty", viol_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
